fuzzy_seq: RTL

FUZZY_SEQ -- requirements
Module: fuzzy_seq

---
 rtl/fuzzy_seq.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fuzzy_seq.sv
// rtl/fuzzy_seq.sv - 3x3 fuzzy rule evaluator with sequential weighted-average defuzzifier
// Build option: FUZZY_SEQ_ROUND_EN selects round-half-up division instead of truncation.
module fuzzy_seq #(
  parameter int ACC_W = 28,
  parameter int SW_W  = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      t_n,
  input  logic [15:0]      t_z,
  input  logic [15:0]      t_p,
  input  logic [15:0]      dt_n,
  input  logic [15:0]      dt_z,
  input  logic [15:0]      dt_p,
  input  logic [7:0]       g_00,
  input  logic [7:0]       g_01,
  input  logic [7:0]       g_02,
  input  logic [7:0]       g_10,
  input  logic [7:0]       g_11,
  input  logic [7:0]       g_12,
  input  logic [7:0]       g_20,
  input  logic [7:0]       g_21,
  input  logic [7:0]       g_22,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       duty,
  output logic [SW_W-1:0]  s_w,
  output logic [ACC_W-1:0] s_wg,
  output logic             zero_w,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACC, DIV, DONE} state_t;

  state_t             state, state_nx;
  logic [3:0]         cnt;
  logic [15:0]        t_r [3];
  logic [15:0]        dt_r [3];
  logic [6:0]         gc_r [9];
  logic [ACC_W-1:0]   rem;
  logic [7:0]         q;

  logic [1:0]         ti, dj;
  logic [3:0]         k;
  logic [15:0]        w;
  logic [22:0]        prod;
  logic [ACC_W+7:0]   div_shift;
  logic               div_bit;
  logic [7:0]         q_final;

  function automatic logic [6:0] clamp100(input logic [7:0] g);
    return (g > 8'd100) ? 7'd100 : g[6:0];
  endfunction

  // Rule k maps to (t index, dt index) = (k/3, k%3).
  always_comb begin
    ti = 2'd0;
    dj = 2'd0;
    k  = (cnt > 4'd8) ? 4'd0 : cnt;
    case (k)
      4'd1: dj = 2'd1;
      4'd2: dj = 2'd2;
      4'd3: ti = 2'd1;
      4'd4: begin ti = 2'd1; dj = 2'd1; end
      4'd5: begin ti = 2'd1; dj = 2'd2; end
      4'd6: ti = 2'd2;
      4'd7: begin ti = 2'd2; dj = 2'd1; end
      4'd8: begin ti = 2'd2; dj = 2'd2; end
      default: ;
    endcase
    w    = (t_r[ti] < dt_r[dj]) ? t_r[ti] : dt_r[dj];
    prod = w * gc_r[k];
  end

  // Restoring division: the quotient is known to fit in 8 bits, so compare against s_w << bit.
  always_comb begin
    div_shift = (ACC_W+8)'(s_w) << cnt[2:0];
    div_bit   = ((ACC_W+8)'(rem) >= div_shift);
    q_final   = {q[6:0], div_bit};
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = ACC;
      ACC:  if (cnt == 4'd9) state_nx = (s_w == '0) ? DONE : DIV;
      DIV:  if (cnt == 4'd0) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == ACC) || (state == DIV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      s_w    <= '0;
      s_wg   <= '0;
      rem    <= '0;
      q      <= '0;
      duty   <= '0;
      zero_w <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        t_r[i]  <= '0;
        dt_r[i] <= '0;
      end
      for (int i = 0; i < 9; i++) gc_r[i] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (in_valid) begin
          t_r[0]  <= t_n;  t_r[1]  <= t_z;  t_r[2]  <= t_p;
          dt_r[0] <= dt_n; dt_r[1] <= dt_z; dt_r[2] <= dt_p;
          gc_r[0] <= clamp100(g_00); gc_r[1] <= clamp100(g_01); gc_r[2] <= clamp100(g_02);
          gc_r[3] <= clamp100(g_10); gc_r[4] <= clamp100(g_11); gc_r[5] <= clamp100(g_12);
          gc_r[6] <= clamp100(g_20); gc_r[7] <= clamp100(g_21); gc_r[8] <= clamp100(g_22);
          s_w    <= '0;
          s_wg   <= '0;
          duty   <= '0;
          zero_w <= 1'b0;
          q      <= '0;
          cnt    <= '0;
        end
        ACC: begin
          if (cnt != 4'd9) begin
            s_w  <= s_w + SW_W'(w);
            s_wg <= s_wg + ACC_W'(prod);
            cnt  <= cnt + 4'd1;
          end else if (s_w == '0) begin
            zero_w <= 1'b1;
            duty   <= '0;
          end else begin
`ifdef FUZZY_SEQ_ROUND_EN
            rem <= s_wg + ACC_W'(s_w >> 1);
`else
            rem <= s_wg;
`endif
            cnt <= 4'd7;
          end
        end
        DIV: begin
          if (div_bit) rem <= rem - div_shift[ACC_W-1:0];
          q <= q_final;
          if (cnt == 4'd0) duty <= (q_final > 8'd100) ? 8'd100 : q_final;
          else             cnt  <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
